alu_exec_stage: RTL

- Execute stage directly downstream of the 8x16 register file.
- Consumes the two operand read values plus opcode and destination address from decode.
- Runs single-cycle ALU ops and iterative 16-cycle MUL/DIV/MOD.
- Returns the result as a one-cycle write-back strobe (load/addr/data) into the register file write port, and updates status flags.

---
 rtl/alu_exec_stage.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_stage.sv
// Execute stage behind the 8x16 register file: single-cycle ALU ops, iterative
// shift-add MUL and restoring DIV/MOD, one-cycle write-back strobe and status flags.
module alu_exec_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [3:0]        ex_opcode,
  input  logic [DATA_W-1:0] ex_op1,
  input  logic [DATA_W-1:0] ex_op2,
  input  logic [ADDR_W-1:0] ex_dest,
  output logic              wb_load,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              flag_v,
  output logic              div_zero,
  output logic              illegal_op,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int SH_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;
  localparam logic [3:0] OP_MOD = 4'd10;
  localparam logic [3:0] OP_MOV = 4'd11;
  localparam logic [3:0] OP_CMP = 4'd12;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_op;
  logic [ADDR_W-1:0] r_dest;
  logic [DATA_W-1:0] r_a;    // multiplicand / dividend shifting into quotient
  logic [DATA_W-1:0] r_b;    // multiplier / divisor
  logic [DATA_W-1:0] r_acc;  // product / partial remainder
  logic              r_wb_load;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_z, r_n, r_c, r_v, r_div_zero, r_illegal;

  // Single-cycle datapath, evaluated directly on the issue inputs.
  logic [DATA_W:0]   w_sum, w_diff, w_shl, w_shr;
  logic [DATA_W-1:0] w_res;
  logic              w_c, w_v, w_write, w_upd, w_dz, w_ill, w_is_iter;

  assign w_sum  = {1'b0, ex_op1} + {1'b0, ex_op2};
  assign w_diff = {1'b0, ex_op1} - {1'b0, ex_op2};
  assign w_shl  = {1'b0, ex_op1} << ex_op2[SH_W-1:0];
  assign w_shr  = {ex_op1, 1'b0} >> ex_op2[SH_W-1:0];
  assign w_is_iter = (ex_opcode == OP_MUL) ||
                     (((ex_opcode == OP_DIV) || (ex_opcode == OP_MOD)) && (ex_op2 != '0));

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    w_res   = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_write = 1'b1;
    w_upd   = 1'b1;
    w_dz    = 1'b0;
    w_ill   = 1'b0;
    case (ex_opcode)
      OP_ADD: begin
        w_res = w_sum[DATA_W-1:0];
        w_c   = w_sum[DATA_W];
        w_v   = (ex_op1[DATA_W-1] == ex_op2[DATA_W-1]) && (w_sum[DATA_W-1] != ex_op1[DATA_W-1]);
      end
      OP_SUB, OP_CMP: begin
        w_res   = w_diff[DATA_W-1:0];
        w_c     = w_diff[DATA_W];
        w_v     = (ex_op1[DATA_W-1] != ex_op2[DATA_W-1]) && (w_diff[DATA_W-1] != ex_op1[DATA_W-1]);
        w_write = (ex_opcode == OP_SUB);
      end
      OP_AND: w_res = ex_op1 & ex_op2;
      OP_OR:  w_res = ex_op1 | ex_op2;
      OP_XOR: w_res = ex_op1 ^ ex_op2;
      OP_NOT: w_res = ~ex_op1;
      OP_SHL: begin
        w_res = w_shl[DATA_W-1:0];
        w_c   = w_shl[DATA_W];
      end
      OP_SHR: begin
        w_res = w_shr[DATA_W:1];
        w_c   = w_shr[0];
      end
      OP_MUL: w_res = '0;
      OP_DIV: begin
        w_res = '1;
        w_dz  = (ex_op2 == '0);
      end
      OP_MOD: begin
        w_res = ex_op1;
        w_dz  = (ex_op2 == '0);
      end
      OP_MOV: w_res = ex_op2;
      default: begin
        w_write = 1'b0;
        w_upd   = 1'b0;
        w_ill   = 1'b1;
      end
    endcase
  end

  // One iteration step of the multiply / restoring divide.
  logic [DATA_W-1:0] w_mul_acc, w_rem_sub, w_rem_next, w_quo_next, w_iter_res;
  logic [DATA_W:0]   w_rem_sh;
  logic              w_rem_ge;

  assign w_mul_acc  = r_b[0] ? (r_acc + r_a) : r_acc;
  assign w_rem_sh   = {r_acc, r_a[DATA_W-1]};
  assign w_rem_ge   = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_sub  = w_rem_sh[DATA_W-1:0] - r_b;
  assign w_rem_next = w_rem_ge ? w_rem_sub : w_rem_sh[DATA_W-1:0];
  assign w_quo_next = {r_a[DATA_W-2:0], w_rem_ge};
  assign w_iter_res = (r_op == OP_MUL) ? w_mul_acc :
                      (r_op == OP_DIV) ? w_quo_next : w_rem_next;

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_dest     <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_wb_load  <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_z        <= 1'b0;
      r_n        <= 1'b0;
      r_c        <= 1'b0;
      r_v        <= 1'b0;
      r_div_zero <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_wb_load <= 1'b0;
      case (r_state)
        S_IDLE: if (ex_valid) begin
          r_op   <= ex_opcode;
          r_dest <= ex_dest;
          if (w_is_iter) begin
            r_state <= S_ITER;
            r_a     <= ex_op1;
            r_b     <= ex_op2;
            r_acc   <= '0;
            r_cnt   <= '0;
          end else begin
            r_state <= S_EXEC;
            if (w_write) begin
              r_wb_load <= 1'b1;
              r_wb_addr <= ex_dest;
              r_wb_data <= w_res;
            end
            if (w_upd) begin
              r_z <= (w_res == '0);
              r_n <= w_res[DATA_W-1];
              r_c <= w_c;
              r_v <= w_v;
            end
            if (w_dz)  r_div_zero <= 1'b1;
            if (w_ill) r_illegal  <= 1'b1;
          end
        end
        S_ITER: begin
          if (r_op == OP_MUL) begin
            r_acc <= w_mul_acc;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
          end else begin
            r_acc <= w_rem_next;
            r_a   <= w_quo_next;
          end
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_state   <= S_WB;
            r_cnt     <= '0;
            r_wb_load <= 1'b1;
            r_wb_addr <= r_dest;
            r_wb_data <= w_iter_res;
            r_z       <= (w_iter_res == '0);
            r_n       <= w_iter_res[DATA_W-1];
            r_c       <= 1'b0;
            r_v       <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;  // EXEC and WB last one cycle
      endcase
    end
  end

  assign ex_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign wb_load    = r_wb_load;
  assign wb_addr    = r_wb_addr;
  assign wb_data    = r_wb_data;
  assign flag_z     = r_z;
  assign flag_n     = r_n;
  assign flag_c     = r_c;
  assign flag_v     = r_v;
  assign div_zero   = r_div_zero;
  assign illegal_op = r_illegal;

endmodule
